// File: rtl/branch_update_queue.sv
// branch_update_queue: in-order tracker of predicted branches.
// Resolves arrive by tag, in any order; each retiring entry sends one predictor update.
module branch_update_queue #(
  parameter int LOCAL_WIDTH = 6,
  parameter int DEPTH_WIDTH = 3,
  parameter int DEPTH = 2**DEPTH_WIDTH
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   alloc_valid,
  input  logic [LOCAL_WIDTH-1:0] alloc_addr,
  input  logic                   alloc_pred,
  output logic                   alloc_ready,
  output logic [DEPTH_WIDTH-1:0] alloc_tag,
  input  logic                   resolve_valid,
  input  logic [DEPTH_WIDTH-1:0] resolve_tag,
  input  logic                   resolve_branch,
  output logic                   transition_signal,
  output logic [LOCAL_WIDTH-1:0] transition_addr,
  output logic                   branch,
  output logic                   mispredict,
  output logic [DEPTH_WIDTH:0]   count
);
  typedef enum logic [1:0] {FREE, PENDING, RESOLVED} state_t;
  state_t                 st     [DEPTH];
  logic [LOCAL_WIDTH-1:0] addr_q [DEPTH];
  logic                   pred_q [DEPTH];
  logic                   act_q  [DEPTH];
  logic [DEPTH_WIDTH-1:0] head, tail;
  logic                   accept, retire, wrong;
  // count never exceeds DEPTH, so its top bit alone marks the queue as full
  assign alloc_ready = ~count[DEPTH_WIDTH];
  assign alloc_tag   = tail;
  assign accept      = alloc_valid && alloc_ready;
  assign retire      = st[head] == RESOLVED;
  assign wrong       = retire && (pred_q[head] != act_q[head]);
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) st[i] <= FREE;
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      transition_signal <= 1'b0;
      transition_addr   <= '0;
      branch            <= 1'b0;
      mispredict        <= 1'b0;
    end else begin
      transition_signal <= retire;
      mispredict        <= wrong;
      if (retire) begin
        transition_addr <= addr_q[head];
        branch          <= act_q[head];
      end
      // a wrong retire flushes everything younger, including this edge's alloc/resolve
      if (wrong) begin
        for (int i = 0; i < DEPTH; i++) st[i] <= FREE;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (retire) begin
          st[head] <= FREE;
          head     <= head + DEPTH_WIDTH'(1);
        end
        if (resolve_valid && st[resolve_tag] == PENDING) begin
          st[resolve_tag]    <= RESOLVED;
          act_q[resolve_tag] <= resolve_branch;
        end
        if (accept) begin
          st[tail]     <= PENDING;
          addr_q[tail] <= alloc_addr;
          pred_q[tail] <= alloc_pred;
          tail         <= tail + DEPTH_WIDTH'(1);
        end
        count <= count + (DEPTH_WIDTH+1)'(accept) - (DEPTH_WIDTH+1)'(retire);
      end
    end
  end
endmodule
